video_fetch_sched: RTL and testbench

Sequences per-character-cell screen fetches for the video generator through the video port of the shared SRAM arbiter. On each cell start it issues up to four back-to-back video reads: bitmap byte, attribute byte, and, with ULAplus enabled, the ink and paper palette entries. It handles the arbiter's request/ack/valid handshake, including pre-emption by CPU and ULAplus traffic. Results go into shadow registers and are committed to the pixel shifter on a load strobe.

---
 rtl/video_fetch_sched.sv | 124 ++++++++++++
 tb/tb_video_fetch_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_sched.sv
// Per-cell screen fetch sequencer: issues bitmap/attribute (and optional ULAplus
// ink/paper palette) reads through the arbiter's video port into shadow registers.
module video_fetch_sched (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [7:0]  fetch_row,
    input  logic [4:0]  fetch_col,
    input  logic        up_en,
    input  logic        cell_load,
    output logic        video_read_req,
    output logic        video_read_req_is_up,
    output logic [14:0] video_read_addr,
    input  logic        video_read_req_ack,
    input  logic        video_data_valid,
    input  logic [7:0]  vd,
    output logic [7:0]  bitmap,
    output logic [7:0]  attr,
    output logic [7:0]  up_ink,
    output logic [7:0]  up_paper,
    output logic        fetch_done,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t     state;
    logic [7:0] row;
    logic [4:0] col;
    logic       up;
    logic [1:0] idx;
    logic [7:0] sh_bitmap, sh_attr, sh_ink, sh_paper;
    logic       last;
    logic [7:0] attr_nxt;

    function automatic logic [14:0] addr_of(input logic [1:0] i, input logic [7:0] y,
                                            input logic [4:0] x, input logic [7:0] a);
        case (i)
            2'd0:    addr_of = {2'b10, y[7:6], y[2:0], y[5:3], x};
            2'd1:    addr_of = {5'b10110, y[7:3], x};
            2'd2:    addr_of = {9'd0, a[7:6], 1'b0, a[2:0]};
            default: addr_of = {9'd0, a[7:6], 1'b1, a[5:3]};
        endcase
    endfunction

    assign last = (idx == (up ? 2'd3 : 2'd1));
    // Palette addresses need the attribute byte, which arrives on vd in the same cycle.
    assign attr_nxt = (idx == 2'd1) ? vd : sh_attr;

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state                <= IDLE;
            row                  <= '0;
            col                  <= '0;
            up                   <= 1'b0;
            idx                  <= '0;
            sh_bitmap            <= '0;
            sh_attr              <= '0;
            sh_ink               <= '0;
            sh_paper             <= '0;
            video_read_req       <= 1'b0;
            video_read_req_is_up <= 1'b0;
            video_read_addr      <= '0;
            bitmap               <= '0;
            attr                 <= '0;
            up_ink               <= '0;
            up_paper             <= '0;
            fetch_done           <= 1'b0;
            overrun              <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            overrun    <= 1'b0;
            if (cell_load) begin
                bitmap   <= sh_bitmap;
                attr     <= sh_attr;
                up_ink   <= sh_ink;
                up_paper <= sh_paper;
            end
            if (fetch_start) begin
                row                  <= fetch_row;
                col                  <= fetch_col;
                up                   <= up_en;
                idx                  <= 2'd0;
                video_read_addr      <= addr_of(2'd0, fetch_row, fetch_col, sh_attr);
                video_read_req_is_up <= 1'b0;
                state                <= REQ;
                // A restart leaves req low for one cycle so a stale ack cannot match it.
                video_read_req       <= (state == IDLE);
                overrun              <= (state != IDLE);
            end else begin
                case (state)
                    REQ: begin
                        if (!video_read_req) begin
                            video_read_req <= 1'b1;
                        end else if (video_read_req_ack) begin
                            video_read_req <= 1'b0;
                            state          <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (video_data_valid) begin
                            case (idx)
                                2'd0:    sh_bitmap <= vd;
                                2'd1:    sh_attr   <= vd;
                                2'd2:    sh_ink    <= vd;
                                default: sh_paper  <= vd;
                            endcase
                            if (last) begin
                                fetch_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                idx                  <= idx + 2'd1;
                                video_read_req       <= 1'b1;
                                video_read_addr      <= addr_of(idx + 2'd1, row, col, attr_nxt);
                                video_read_req_is_up <= (idx != 2'd0);
                                state                <= REQ;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_video_fetch_sched.sv
// Directed bench for video_fetch_sched: arbiter responder, cell-level reference
// model with per-cycle compare, plus hand-computed expectations per scenario.
module tb_video_fetch_sched;
    logic        clk28 = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic [7:0]  fetch_row = '0;
    logic [4:0]  fetch_col = '0;
    logic        up_en = 1'b0;
    logic        cell_load = 1'b0;
    logic        video_read_req, video_read_req_is_up;
    logic [14:0] video_read_addr;
    logic        video_read_req_ack = 1'b0;
    logic        video_data_valid = 1'b0;
    logic [7:0]  vd = '0;
    logic [7:0]  bitmap, attr, up_ink, up_paper;
    logic        fetch_done, overrun;

    always #5 clk28 = ~clk28;

    video_fetch_sched dut (
        .clk28(clk28), .rst_n(rst_n), .fetch_start(fetch_start),
        .fetch_row(fetch_row), .fetch_col(fetch_col), .up_en(up_en),
        .cell_load(cell_load), .video_read_req(video_read_req),
        .video_read_req_is_up(video_read_req_is_up), .video_read_addr(video_read_addr),
        .video_read_req_ack(video_read_req_ack), .video_data_valid(video_data_valid),
        .vd(vd), .bitmap(bitmap), .attr(attr), .up_ink(up_ink), .up_paper(up_paper),
        .fetch_done(fetch_done), .overrun(overrun)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Stimulus knobs: per-cell read data, arbiter hold (pre-emption), video latency.
    logic [7:0] dat [4];
    logic       hold = 1'b0;
    int         vlat = 1;

    // Reference model state (cell-level view).
    int          cyc = 0, gen = 0;
    bit          live = 0, m_busy = 0, m_done = 0, m_ovr = 0;
    int          m_ptr = 0, m_n = 0;
    logic [7:0]  m_sh [4];
    logic [7:0]  m_out [4];
    logic [15:0] plan [4];
    // Arbiter snapshot taken at the clock edge, consumed on the following negedge.
    bit          a_req = 0, a_hold = 0, s_ack = 0, s_req = 0;
    int          a_gen = 0, a_ptr = 0, a_lat = 1;
    logic [7:0]  a_dat [4];
    int          vcnt = 0, ptag = 0, vtag = -1;
    logic [7:0]  pdata = '0;
    // Observation logs for the literal checks.
    logic [15:0] rd_log [$];
    int          start_cyc = 0, done_cyc = 0, n_done = 0, n_ovr = 0;

    always @(posedge clk28) begin
        int g0, p0, y, x, a;
        cyc++;
        g0 = gen;
        p0 = m_ptr;
        if (fetch_done === 1'b1) begin n_done++; done_cyc = cyc - 1; end
        if (overrun === 1'b1) n_ovr++;
        if (video_read_req_ack && video_read_req === 1'b1)
            rd_log.push_back({video_read_req_is_up, video_read_addr});
        s_ack  = video_read_req_ack;
        s_req  = (video_read_req === 1'b1);
        a_req  = s_req;
        a_gen  = g0;
        a_ptr  = p0;
        a_hold = hold;
        a_lat  = vlat;
        a_dat  = dat;
        m_done = 0;
        m_ovr  = 0;
        if (!rst_n) begin
            live = 1; gen++; m_busy = 0; m_ptr = 0;
            for (int i = 0; i < 4; i++) begin m_sh[i] = '0; m_out[i] = '0; end
        end else begin
            if (cell_load) m_out = m_sh;
            if (fetch_start) begin
                m_ovr = m_busy; gen++; m_busy = 1; m_ptr = 0;
                m_n = up_en ? 4 : 2; start_cyc = cyc;
                y = int'(fetch_row); x = int'(fetch_col); a = int'(dat[1]);
                plan[0] = 16'(32'h4000 + (y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + x);
                plan[1] = 16'(32'h5800 + (y / 8) * 32 + x);
                plan[2] = 16'(32'h8000 + (a / 64) * 16 + (a % 8));
                plan[3] = 16'(32'h8000 + (a / 64) * 16 + 8 + ((a / 8) % 8));
            end else if (m_busy && video_data_valid && vtag == g0) begin
                m_sh[m_ptr] = vd;
                if (m_ptr == m_n - 1) begin m_done = 1; m_busy = 0; end
                else m_ptr++;
            end
        end
    end

    // Arbiter: registered ack one cycle after req, one request in flight, data after vlat.
    always @(negedge clk28) begin
        logic nack;
        nack = a_req && !video_read_req_ack && !a_hold && vcnt == 0;
        video_data_valid = 1'b0;
        if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) begin video_data_valid = 1'b1; vd = pdata; vtag = ptag; end
        end
        video_read_req_ack = nack;
        if (nack) begin vcnt = a_lat; pdata = a_dat[a_ptr]; ptag = a_gen; end
    end

    always @(negedge clk28) begin
        if (live) begin
            check("bitmap", bitmap, m_out[0]);
            check("attr", attr, m_out[1]);
            check("up_ink", up_ink, m_out[2]);
            check("up_paper", up_paper, m_out[3]);
            check("fetch_done", fetch_done, m_done);
            check("overrun", overrun, m_ovr);
            if (!m_busy) check("req_idle", video_read_req, 0);
            else if (video_read_req === 1'b1)
                check("req_addr", {video_read_req_is_up, video_read_addr}, plan[m_ptr]);
            if (s_ack && s_req) check("req_after_ack", video_read_req, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk28);
    endtask

    task automatic start(input logic [7:0] r, input logic [4:0] c, input logic u);
        fetch_row = r; fetch_col = c; up_en = u; fetch_start = 1'b1;
        @(negedge clk28);
        fetch_start = 1'b0;
    endtask

    task automatic load();
        cell_load = 1'b1;
        @(negedge clk28);
        cell_load = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete(); n_done = 0; n_ovr = 0; done_cyc = -1;
    endtask

    function automatic logic [15:0] logat(input int i);
        return (rd_log.size() > i) ? rd_log[i] : 16'hDEAD;
    endfunction

    initial begin
        dat = '{8'h00, 8'h00, 8'h00, 8'h00};
        tick(3);
        check("rst_req", video_read_req, 0);
        check("rst_addr", {video_read_req_is_up, video_read_addr}, 0);
        check("rst_bitmap", bitmap, 0);
        check("rst_flags", {fetch_done, overrun}, 0);
        rst_n = 1'b1;
        tick(2);

        // Uncontended 2-read cell.
        dat = '{8'hAA, 8'h38, 8'h00, 8'h00};
        clear_logs();
        start(8'd0, 5'd0, 1'b0);
        tick(12);
        check("t1_reads", rd_log.size(), 2);
        check("t1_addr0", logat(0), 16'h4000);
        check("t1_addr1", logat(1), 16'h5800);
        check("t1_done_lat", done_cyc - start_cyc, 6);
        check("t1_ndone", n_done, 1);
        load();
        check("t1_bitmap", bitmap, 8'hAA);
        check("t1_attr", attr, 8'h38);

        // ULAplus 4-read cell.
        dat = '{8'h11, 8'hC5, 8'h77, 8'h99};
        clear_logs();
        start(8'd0, 5'd0, 1'b1);
        tick(16);
        check("t3_reads", rd_log.size(), 4);
        check("t3_ink_addr", logat(2), 16'h8035);
        check("t3_paper_addr", logat(3), 16'h8038);
        check("t3_done_lat", done_cyc - start_cyc, 12);
        load();
        check("t3_attr", attr, 8'hC5);
        check("t3_ink", up_ink, 8'h77);
        check("t3_paper", up_paper, 8'h99);

        // Address mapping corner; palette shadows must survive an up_en=0 cell.
        dat = '{8'hF0, 8'h0F, 8'h00, 8'h00};
        clear_logs();
        start(8'd191, 5'd31, 1'b0);
        tick(12);
        check("t2_addr0", logat(0), 16'h57FF);
        check("t2_addr1", logat(1), 16'h5AFF);
        load();
        check("t2_bitmap", bitmap, 8'hF0);
        check("t2_ink_kept", up_ink, 8'h77);
        check("t2_paper_kept", up_paper, 8'h99);

        // Pre-emption during the attribute request.
        dat = '{8'h3C, 8'h47, 8'h00, 8'h00};
        clear_logs();
        start(8'd0, 5'd0, 1'b0);
        tick(3);
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t4_req_held", {video_read_req, video_read_req_is_up, video_read_addr}, 17'h15800);
        end
        hold = 1'b0;
        tick(12);
        check("t4_reads", rd_log.size(), 2);
        check("t4_ndone", n_done, 1);
        load();
        check("t4_bitmap", bitmap, 8'h3C);
        check("t4_attr", attr, 8'h47);

        // Overrun: second fetch_start four edges after the first.
        dat = '{8'h55, 8'h66, 8'h00, 8'h00};
        clear_logs();
        start(8'd0, 5'd0, 1'b0);
        tick(3);
        start(8'd64, 5'd1, 1'b0);
        check("t5_req_drop", video_read_req, 0);
        tick(1);
        check("t5_restart", {video_read_req, video_read_addr}, 16'hC801);
        tick(14);
        check("t5_novr", n_ovr, 1);
        check("t5_ndone", n_done, 1);
        load();
        check("t5_bitmap", bitmap, 8'h55);

        // Reset while waiting for data; the late valid must be dropped.
        vlat = 3;
        dat = '{8'h5A, 8'hA5, 8'h00, 8'h00};
        start(8'd0, 5'd0, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_req", {video_read_req, video_read_req_is_up, video_read_addr}, 0);
        check("t6_outs", {bitmap, attr, up_ink, up_paper}, 0);
        check("t6_flags", {fetch_done, overrun}, 0);
        tick(4);
        vlat = 1;
        load();
        check("t6_bitmap_late", bitmap, 8'h00);
        check("t6_attr_late", attr, 8'h00);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
